hazard_stall_controller: RTL and testbench

- Pipeline hazard sequencer for the 5-stage MIPS core. It sits beside the ID-stage and WB-stage forwarding units.
- Detects hazards that forwarding cannot resolve: load-use, branch operands produced by an in-flight load, multi-cycle divide occupancy, and data-memory wait.
- Drives the PC and pipeline-register write-enable/flush controls.
- Sequences stalls with an FSM, so multi-cycle stalls are counted here and not inferred by the datapath.

---
 rtl/hazard_stall_controller.sv | 179 +++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard sequencer for the 5-stage MIPS core: load-use, branch-after-load, divide occupancy, data-memory wait.
// Optional stall performance counter enabled by defining HAZARD_STALL_PERF_EN.
module hazard_stall_controller #(
    parameter int DIV_LATENCY = 32,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_is_branch,
    input  logic                  id_is_div,
    input  logic                  id_reads_hilo,
    input  logic                  id_ex_MemRead,
    input  logic                  id_ex_RegWrite,
    input  logic [REG_ADDR_W-1:0] id_ex_write_register,
    input  logic                  ex_mem_MemRead,
    input  logic [REG_ADDR_W-1:0] ex_mem_write_register,
    input  logic                  branch_taken,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  pipe_hold,
    output logic                  div_busy,
    output logic [15:0]           stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_LATENCY);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_div_cnt;

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_lu;
    logic w_br1;
    logic w_br2;
    logic w_dv;
    logic w_mem_wait;
    logic w_run_slot;
    logic w_div_accept;

    // Destination register 0 never matches a source.
    assign w_ex_hit  = (id_ex_write_register != '0) &&
                       ((id_ex_write_register == id_rs) ||
                        (id_uses_rt && (id_ex_write_register == id_rt)));
    assign w_mem_hit = (ex_mem_write_register != '0) &&
                       ((ex_mem_write_register == id_rs) ||
                        (id_uses_rt && (ex_mem_write_register == id_rt)));

    assign w_lu       = id_ex_MemRead & w_ex_hit;
    assign w_br1      = id_is_branch & id_ex_RegWrite & w_ex_hit;
    assign w_br2      = id_is_branch & ex_mem_MemRead & w_mem_hit;
    assign div_busy   = (r_div_cnt != 8'd0);
    assign w_dv       = (id_is_div | id_reads_hilo) & div_busy;
    assign w_mem_wait = ex_mem_MemRead & ~dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_hold    = 1'b0;
        w_div_accept = 1'b0;
        w_run_slot   = 1'b0;

        case (r_state)
            RUN: begin
                w_run_slot = 1'b1;
            end
            MEM_WAIT: begin
                pipe_hold   = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (dmem_ready) begin
                    w_state_next = RUN;
                end
            end
            DIV_WAIT: begin
                if (w_mem_wait) begin
                    pipe_hold    = 1'b1;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    w_state_next = MEM_WAIT;
                end else if (div_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else begin
                    // Divider just drained: the waiting instruction issues this cycle.
                    w_run_slot = 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase

        if (w_run_slot) begin
            if (w_mem_wait) begin
                pipe_hold    = 1'b1;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                w_state_next = MEM_WAIT;
            end else if (w_dv) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_flush  = 1'b1;
                w_state_next = DIV_WAIT;
            end else if (w_lu | w_br1 | w_br2) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_flush  = 1'b1;
                w_state_next = RUN;
            end else begin
                if_id_flush  = branch_taken;
                w_div_accept = id_is_div;
                w_state_next = RUN;
            end
        end

        // Outputs show their reset values while reset is held.
        if (!rst_n) begin
            w_state_next = RUN;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            pipe_hold    = 1'b0;
            w_div_accept = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 8'd0;
        end else if (w_div_accept) begin
            r_div_cnt <= DIV_LOAD;
        end else if (r_div_cnt != 8'd0) begin
            r_div_cnt <= r_div_cnt - 8'd1;
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed testbench for hazard_stall_controller (DIV_LATENCY = 4).
// Output vector bits: {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, div_busy}.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_is_branch;
    logic       id_is_div;
    logic       id_reads_hilo;
    logic       id_ex_MemRead;
    logic       id_ex_RegWrite;
    logic [4:0] id_ex_write_register;
    logic       ex_mem_MemRead;
    logic [4:0] ex_mem_write_register;
    logic       branch_taken;
    logic       dmem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       pipe_hold;
    logic       div_busy;
    logic [15:0] stall_cycles;

    int n_checks;
    int n_pass;

    localparam logic [5:0] NORM  = 6'b110000;
    localparam logic [5:0] FLUSH = 6'b111000;
    localparam logic [5:0] STALL = 6'b000100;
    localparam logic [5:0] HOLD  = 6'b000010;
    localparam logic [5:0] DSTL  = 6'b000101;

`ifdef HAZARD_STALL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    hazard_stall_controller #(
        .DIV_LATENCY(4),
        .REG_ADDR_W (5)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .id_rs                (id_rs),
        .id_rt                (id_rt),
        .id_uses_rt           (id_uses_rt),
        .id_is_branch         (id_is_branch),
        .id_is_div            (id_is_div),
        .id_reads_hilo        (id_reads_hilo),
        .id_ex_MemRead        (id_ex_MemRead),
        .id_ex_RegWrite       (id_ex_RegWrite),
        .id_ex_write_register (id_ex_write_register),
        .ex_mem_MemRead       (ex_mem_MemRead),
        .ex_mem_write_register(ex_mem_write_register),
        .branch_taken         (branch_taken),
        .dmem_ready           (dmem_ready),
        .pc_write             (pc_write),
        .if_id_write          (if_id_write),
        .if_id_flush          (if_id_flush),
        .id_ex_flush          (id_ex_flush),
        .pipe_hold            (pipe_hold),
        .div_busy             (div_busy),
        .stall_cycles         (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] w_outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, div_busy};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", tag, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sc(input int n);
        return PERF_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_uses_rt = 0; id_is_branch = 0;
        id_is_div = 0; id_reads_hilo = 0; id_ex_MemRead = 0; id_ex_RegWrite = 0;
        id_ex_write_register = '0; ex_mem_MemRead = 0; ex_mem_write_register = '0;
        branch_taken = 0; dmem_ready = 1;
    endtask

    // Evaluates one cycle: inputs were applied at posedge+1, outputs checked at posedge+4.
    task automatic cyc(input string tag, input logic [5:0] exp);
        #3;
        check(tag, 32'(w_outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ex_load(input logic [4:0] dst);
        id_ex_MemRead = 1; id_ex_RegWrite = 1; id_ex_write_register = dst;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        clr_in();
        #2;
        check("reset_outs", 32'(w_outs), 32'(NORM));
        check("reset_cnt", 32'(stall_cycles), 32'd0);
        do_reset();

        // Load-use on rs: exactly one stall cycle.
        set_ex_load(5'd8); id_rs = 5'd8; id_rt = 5'd3; id_uses_rt = 1;
        cyc("lu_stall", STALL);
        id_ex_MemRead = 0; id_ex_RegWrite = 0; id_ex_write_register = '0;
        ex_mem_MemRead = 1; ex_mem_write_register = 5'd8;
        cyc("lu_release", NORM);
        check("lu_cnt", 32'(stall_cycles), sc(1));

        // Load-use on rt only counts when rt is read.
        clr_in(); set_ex_load(5'd7); id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1;
        cyc("lu_rt", STALL);
        clr_in(); set_ex_load(5'd7); id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 0;
        cyc("lu_rt_unused", NORM);

        // Register 0 destination never stalls.
        clr_in(); set_ex_load(5'd0); id_rs = 5'd0;
        cyc("reg0", NORM);

        // Branch operand from ALU result in EX (br1).
        clr_in(); id_ex_RegWrite = 1; id_ex_write_register = 5'd4;
        id_is_branch = 1; id_rs = 5'd9; id_rt = 5'd4; id_uses_rt = 1;
        cyc("br1_stall", STALL);

        // Branch after load: 2 stall cycles, flush suppressed, then flush.
        clr_in(); do_reset();
        set_ex_load(5'd5); id_is_branch = 1; id_rs = 5'd5; id_rt = 5'd6; id_uses_rt = 1;
        branch_taken = 1;
        cyc("brld_stall1", STALL);
        id_ex_MemRead = 0; id_ex_RegWrite = 0; id_ex_write_register = '0;
        ex_mem_MemRead = 1; ex_mem_write_register = 5'd5;
        cyc("brld_stall2", STALL);
        ex_mem_MemRead = 0; ex_mem_write_register = '0;
        cyc("brld_flush", FLUSH);
        check("brld_cnt", 32'(stall_cycles), sc(2));
        clr_in();
        cyc("brld_after", NORM);

        // Divide conflict: mflo waits 4 cycles, issues in the 5th.
        do_reset();
        id_is_div = 1;
        cyc("div_issue", NORM);
        id_is_div = 0; id_reads_hilo = 1;
        cyc("div_wait1", DSTL);
        cyc("div_wait2", DSTL);
        cyc("div_wait3", DSTL);
        cyc("div_wait4", DSTL);
        cyc("div_mflo_issue", NORM);
        check("div_cnt", 32'(stall_cycles), sc(4));
        clr_in();
        cyc("div_idle", NORM);

        // Memory wait with concurrent load-use: 3 hold cycles, then 1 load-use stall.
        do_reset();
        ex_mem_MemRead = 1; ex_mem_write_register = 5'd2; dmem_ready = 0;
        set_ex_load(5'd8); id_rs = 5'd8;
        cyc("mem_hold1", HOLD);
        cyc("mem_hold2", HOLD);
        dmem_ready = 1;
        cyc("mem_hold3", HOLD);
        ex_mem_MemRead = 0; ex_mem_write_register = '0;
        cyc("mem_lu", STALL);
        clr_in();
        cyc("mem_done", NORM);
        check("mem_cnt", 32'(stall_cycles), sc(4));

        // Asynchronous reset in the middle of DIV_WAIT.
        do_reset();
        id_is_div = 1;
        cyc("rdiv_issue", NORM);
        id_is_div = 0; id_reads_hilo = 1;
        cyc("rdiv_wait1", DSTL);
        cyc("rdiv_wait2", DSTL);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_div_busy", 32'(div_busy), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd1);
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_first_run", NORM);
        check("rst_cnt_after", 32'(stall_cycles), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
